// File: rtl/ddr_cfg_seq_responder_if.sv
// Reset/start wires driven by the DDR reset sequencer, plus the status the
// emulated configuration/calibration sequencer returns on the same bundle.
interface ddr_cfg_seq_responder_if;
    logic       ddr_cfg_seq_rst;
    logic       ddr_cfg_seq_start;
    logic       ddr_cfg_busy;
    logic       ddr_cfg_done;
    logic [2:0] ddr_cfg_err;
    logic [3:0] ddr_cfg_restarts;
    logic [2:0] ddr_cfg_state;

    modport master (
        output ddr_cfg_seq_rst,
        output ddr_cfg_seq_start,
        input  ddr_cfg_busy,
        input  ddr_cfg_done,
        input  ddr_cfg_err,
        input  ddr_cfg_restarts,
        input  ddr_cfg_state
    );

    modport slave (
        input  ddr_cfg_seq_rst,
        input  ddr_cfg_seq_start,
        output ddr_cfg_busy,
        output ddr_cfg_done,
        output ddr_cfg_err,
        output ddr_cfg_restarts,
        output ddr_cfg_state
    );
endinterface

// File: rtl/ddr_cfg_seq_responder.sv
// Emulates the controller's configuration/calibration sequencer answering the
// DDR reset interface, and records sticky reset/start protocol violations.
module ddr_cfg_seq_responder #(
    parameter int CFG_CYCLES    = 64,
    parameter int CALIB_CYCLES  = 256,
    parameter int START_TIMEOUT = 16,
    parameter int CNT_W         = 16
) (
    input  logic                    clk,
    input  logic                    ddr_rstn_i,
    ddr_cfg_seq_responder_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_ARMED = 3'd1,
        ST_CFG   = 3'd2,
        ST_CALIB = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CFG_LAST   = CNT_W'(CFG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CALIB_LAST = CNT_W'(CALIB_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(START_TIMEOUT);

    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_EARLY   = 1;
    localparam int ERR_DROP    = 2;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       err_q, err_d;
    logic [3:0]       restarts_q, restarts_d;
    logic             busy_q, done_q;

    logic seq_rst;
    logic seq_start;

    assign seq_rst   = bus.ddr_cfg_seq_rst;
    assign seq_start = bus.ddr_cfg_seq_start;

    // cnt is the phase countdown in CFG/CALIB and the start-wait count in ARMED.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no branch can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        restarts_d = restarts_q;

        unique case (state_q)
            ST_RST: begin
                if (seq_rst) begin
                    if (seq_start) begin
                        err_d[ERR_EARLY] = 1'b1;
                    end
                end else begin
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                end
            end

            ST_ARMED: begin
                if (seq_rst) begin
                    state_d = ST_RST;
                    cnt_d   = '0;
                end else if (seq_start) begin
                    state_d = ST_CFG;
                    cnt_d   = CFG_LAST;
                end else begin
                    if (cnt_q < TIMEOUT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_d == TIMEOUT) begin
                        err_d[ERR_TIMEOUT] = 1'b1;
                    end
                end
            end

            ST_CFG, ST_CALIB: begin
                if (seq_rst) begin
                    state_d = ST_RST;
                    cnt_d   = '0;
                    if (restarts_q != 4'hF) begin
                        restarts_d = restarts_q + 4'd1;
                    end
                end else if (!seq_start) begin
                    state_d        = ST_ARMED;
                    cnt_d          = '0;
                    err_d[ERR_DROP] = 1'b1;
                end else if (cnt_q == '0) begin
                    // Transition is taken at zero, so the countdown never wraps.
                    if (state_q == ST_CFG) begin
                        state_d = ST_CALIB;
                        cnt_d   = CALIB_LAST;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_DONE: begin
                if (seq_rst) begin
                    state_d = ST_RST;
                    cnt_d   = '0;
                    if (restarts_q != 4'hF) begin
                        restarts_d = restarts_q + 4'd1;
                    end
                end else if (!seq_start) begin
                    err_d[ERR_DROP] = 1'b1;
                end
            end

            default: begin
                state_d = ST_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // busy/done are registered from the next state so they change with state_q.
    always_ff @(posedge clk or negedge ddr_rstn_i) begin
        if (!ddr_rstn_i) begin
            state_q    <= ST_RST;
            cnt_q      <= '0;
            err_q      <= '0;
            restarts_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values together.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            restarts_q <= restarts_d;
            busy_q     <= (state_d == ST_CFG) || (state_d == ST_CALIB);
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign bus.ddr_cfg_busy     = busy_q;
    assign bus.ddr_cfg_done     = done_q;
    assign bus.ddr_cfg_err      = err_q;
    assign bus.ddr_cfg_restarts = restarts_q;
    assign bus.ddr_cfg_state    = state_q;

endmodule
